// File: rtl/pixel_spi_out.sv
// pixel_spi_out: buffers 24-bit RGB pixels in a small FIFO and serializes
// each one MSB-first over a mode-0 SPI master link (sclk idles low, data
// sampled by the receiver on the rising edge, changed on the falling edge).
// Optional build macro PIXEL_SPI_PARITY_EN appends an even-parity bit
// (XOR of the 24 pixel bits) after bit 0, making 25-bit frames.
module pixel_spi_out #(
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid_in,
  input  logic [23:0] color_in,
  output logic        ready,
  output logic        overflow,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi
);

  localparam int DATA_W = 24;
`ifdef PIXEL_SPI_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NBITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Serializer datapath
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sclk_q;
  logic              cs_n_q;
  logic [NBITS-1:0]  shreg_q;
  logic [NBITS-1:0]  load_word;
  logic              div_wrap;
  logic              sclk_fall;
  logic              last_fall;

  assign head = mem[rd_ptr_q];

`ifdef PIXEL_SPI_PARITY_EN
  assign load_word = {head, ^head};
`else
  assign load_word = head;
`endif

  // ready is decoded from the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign ready = (count_q != CNT_FULL);
  assign push  = valid_in && ready;

  assign div_wrap  = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign sclk_fall = div_wrap && sclk_q;
  assign last_fall = sclk_fall && (bit_q == BIT_LAST);

  // Next-state decode and pop strobe
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (count_q != '0) state_d = LOAD;
      LOAD:  begin
               pop     = 1'b1;
               state_d = SHIFT;
             end
      SHIFT: if (last_fall) state_d = GAP;
      GAP:   if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= color_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (valid_in && !ready) overflow_q <= 1'b1;
    end
  end

  // Shift register: loaded from the FIFO head, shifted on each sclk fall
  always_ff @(posedge clk) begin
    if (state_q == LOAD)  shreg_q <= load_word;
    else if (sclk_fall)   shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
  end

  // SPI control: clock divider, bit counter, chip select and gap timer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_q  <= '0;
      bit_q  <= '0;
      gap_q  <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          cs_n_q <= 1'b0;
          sclk_q <= 1'b0;
          div_q  <= '0;
          bit_q  <= '0;
        end
        SHIFT: begin
          if (div_wrap) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              bit_q <= bit_q + BIT_W'(1);
              if (last_fall) begin
                cs_n_q <= 1'b1;
                gap_q  <= '0;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        GAP: gap_q <= gap_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // The top of the shift register is the bit on the wire while selected;
  // gating with chip select keeps mosi low in reset, idle and gap.
  assign spi_mosi = shreg_q[NBITS-1] & ~cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign overflow = overflow_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_pixel_spi_out.sv
// Testbench for pixel_spi_out: randomized and directed pixel traffic, a
// transaction-level occupancy/timing model, and an SPI monitor that
// decodes frames and checks them against a queue of accepted pixels.
module tb_pixel_spi_out;

  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 2;
`ifdef PIXEL_SPI_PARITY_EN
  localparam int NBITS = 25;
`else
  localparam int NBITS = 24;
`endif
  localparam int SHIFT_CYC = 2 * NBITS * CLK_DIV;
  localparam int FRAME_X   = SHIFT_CYC + 2 * CLK_DIV;

  logic        clk;
  logic        nrst;
  logic        valid_in;
  logic [23:0] color_in;
  logic        ready;
  logic        overflow;
  logic        busy;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;

  pixel_spi_out #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .valid_in (valid_in),
    .color_in (color_in),
    .ready    (ready),
    .overflow (overflow),
    .busy     (busy),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of accepted pixels awaiting serialization
  logic [23:0] exp_q[$];

  // Reference model state
  int m_count;
  int cyc;
  int free_at;
  bit ld_pend;
  bit m_ovf;
  bit m_busy;

  // Monitor state
  bit          in_frame;
  int          mon_bits;
  int          low_cycles;
  logic [31:0] word;
  logic        prev_sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [23:0] c);
`ifdef PIXEL_SPI_PARITY_EN
    return {7'b0, c, ^c};
`else
    return {8'b0, c};
`endif
  endfunction

  task automatic model_reset();
    m_count = 0;
    cyc     = 0;
    free_at = 0;
    ld_pend = 0;
    m_ovf   = 0;
    m_busy  = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the
  // rising edge, check the status outputs just after it.
  task automatic step(input bit v, input logic [23:0] c);
    bit pop;
    bit nxt;
    bit acc;
    valid_in = v;
    color_in = c;
    @(posedge clk);
    pop = ld_pend;
    nxt = 0;
    if (ld_pend) free_at = cyc + FRAME_X + 1;
    else if (cyc >= free_at && m_count != 0) nxt = 1;
    acc = v && (m_count != FIFO_DEPTH);
    if (v && !acc) m_ovf = 1;
    if (acc) exp_q.push_back(c);
    m_count = m_count + int'(acc) - int'(pop);
    ld_pend = nxt;
    m_busy  = (m_count != 0) || ld_pend || (cyc < free_at - 1);
    cyc++;
    #1;
    chk("ready", ready, (m_count != FIFO_DEPTH));
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_busy);
    @(negedge clk);
  endtask

  // Asynchronous reset in mid-cycle; outputs must react without a clock edge.
  task automatic do_reset();
    #2 nrst = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_mosi", spi_mosi, 0);
    model_reset();
    valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 3000) begin
      step(0, 24'h0);
      n++;
    end
    chk("drain_timeout", (n < 3000), 1);
  endtask

  // SPI monitor: collects bits on sclk rising edges while selected and
  // checks each completed frame against the scoreboard.
  always @(negedge clk) begin
    if (!nrst) begin
      in_frame   = 0;
      mon_bits   = 0;
      low_cycles = 0;
      prev_sclk  = 1'b0;
    end else begin
      if (spi_cs_n) begin
        chk("idle_sclk", spi_sclk, 0);
        if (in_frame) begin
          in_frame = 0;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", word, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] e;
            e = frame_of(exp_q.pop_front());
            chk("frame_data", word & ((32'h1 << NBITS) - 1), e);
            chk("frame_bits", mon_bits, NBITS);
            chk("frame_cs_low_cycles", low_cycles, SHIFT_CYC);
          end
        end
      end else begin
        if (!in_frame) begin
          in_frame   = 1;
          mon_bits   = 0;
          low_cycles = 0;
          word       = '0;
        end
        low_cycles++;
        if (spi_sclk && !prev_sclk) begin
          word = {word[30:0], spi_mosi};
          mon_bits++;
        end
      end
      prev_sclk = spi_sclk;
    end
  end

  initial begin
    logic [23:0] rc;
    int          rate;
    int          n;
    nrst     = 1'b0;
    valid_in = 1'b0;
    color_in = 24'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset
    repeat (5) step(0, 24'h0);
    chk("idle_cs_n", spi_cs_n, 1);
    chk("idle_sclk_lvl", spi_sclk, 0);

    // Single pixel: chip select falls two edges after the push edge
    step(1, 24'hA5C30F);
    chk("cs_n_after_push", spi_cs_n, 1);
    step(0, 24'h0);
    chk("cs_n_in_load", spi_cs_n, 1);
    step(0, 24'h0);
    chk("cs_n_in_shift", spi_cs_n, 0);
    chk("mosi_first_bit", spi_mosi, 1);
    drain();

    // Parity-relevant pixels (plain frames in the default build)
    step(1, 24'h000001);
    step(1, 24'h000003);
    drain();

    // Burst of six on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      rc = 24'($urandom());
      step(1, rc);
    end
    chk("burst_overflow", overflow, 1);
    drain();

    // Full FIFO with a push held through the LOAD cycle
    do_reset();
    step(1, 24'($urandom()));
    repeat (3) step(0, 24'h0);
    for (int i = 0; i < 130; i++) begin
      rc = 24'($urandom());
      step(1, rc);
    end
    chk("full_overflow", overflow, 1);
    drain();

    // Reset in the middle of a frame
    do_reset();
    step(1, 24'hFFFFFF);
    n = 0;
    while (!(in_frame && mon_bits >= 10) && n < 500) begin
      step(0, 24'h0);
      n++;
    end
    chk("mid_frame_wait", (n < 500), 1);
    do_reset();
    step(1, 24'h5A3C96);
    drain();

    // Randomized traffic at varying densities
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: rate = 3;
        1: rate = 60;
        2: rate = 1;
        3: rate = 30;
        default: rate = 100;
      endcase
      for (int i = 0; i < 500; i++) begin
        rc = 24'($urandom());
        step(($urandom_range(0, 99) < rate), rc);
      end
    end
    drain();
    repeat (4) step(0, 24'h0);
    chk("leftover_frames", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
